// File: rtl/sclk_frame_gen_pkg.sv
// sclk_pkg: shared state encoding and default widths for the serial clock/frame generator.
package sclk_pkg;

  localparam int HALF_W_DEF = 8;
  localparam int BITS_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } state_t;

endpackage

// File: rtl/sclk_frame_gen_half_cnt.sv
// sclk_half_cnt: half-period counter, 0..half-1 with wrap; tick marks the last cycle.
// Held at zero while clr is high so every frame starts on a fresh half-period.
module sclk_half_cnt
  import sclk_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [HALF_W-1:0] half,
  output logic              tick
);

  logic [HALF_W-1:0] cnt;

  assign tick = !clr && (cnt == (half - HALF_W'(1)));

  // Count within the half-period; restart on wrap or while cleared.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + HALF_W'(1);
    end
  end

endmodule

// File: rtl/sclk_frame_gen.sv
// sclk_frame_gen: one start request produces one chip-select frame of N serial clocks,
// with lead/trail edge strobes and a completed-bit counter for the shifter/sampler.
module sclk_frame_gen
  import sclk_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF,
  parameter int BITS_W = BITS_W_DEF
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [HALF_W-1:0] half_div,
  input  logic [BITS_W-1:0] nbits,
  input  logic              cpol,
  output logic              sclk,
  output logic              cs_n,
  output logic              lead_pulse,
  output logic              trail_pulse,
  output logic [BITS_W-1:0] step,
  output logic              busy,
  output logic              done
);

  state_t            state_q;
  state_t            state_nxt;
  logic [HALF_W-1:0] h_lat;
  logic [BITS_W-1:0] n_lat;
  logic              cpol_lat;
  logic              tick;
  logic              accept;
  logic              toggle;
  logic              finish;
  logic              kill;
  logic              lead_nxt;
  logic              trail_nxt;

  sclk_half_cnt #(
    .HALF_W (HALF_W)
  ) u_half_cnt (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (state_q == IDLE),
    .half    (h_lat),
    .tick    (tick)
  );

  // A toggle away from the idle level is a leading edge, back to it a trailing edge.
  assign lead_nxt  = toggle && (sclk == cpol_lat);
  assign trail_nxt = toggle && (sclk != cpol_lat);

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state and per-cycle actions; abort always beats tick and start.
  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    toggle    = 1'b0;
    finish    = 1'b0;
    kill      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort && (nbits != '0)) begin
          accept    = 1'b1;
          state_nxt = LEAD;
        end
      end
      LEAD: begin
        if (abort) begin
          kill = 1'b1;
        end else if (tick) begin
          toggle    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          kill = 1'b1;
        end else if (tick) begin
          // All N bits clocked and sclk back at idle level: the 2N toggles are done.
          if ((step == n_lat) && (sclk == cpol_lat)) begin
            state_nxt = TRAIL;
          end else begin
            toggle = 1'b1;
          end
        end
      end
      TRAIL: begin
        if (abort) begin
          kill = 1'b1;
        end else if (tick) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (kill) begin
      state_nxt = IDLE;
    end
  end

  // Frame parameters captured on accept and held for the whole frame; H=0 runs as H=1.
  always_ff @(posedge clk_sys) begin
    if (accept) begin
      h_lat <= (half_div == '0) ? HALF_W'(1) : half_div;
      n_lat <= nbits;
    end
  end

  // Registered outputs: serial clock, chip select, strobes, bit counter and status.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sclk        <= 1'b1;
      cs_n        <= 1'b1;
      lead_pulse  <= 1'b0;
      trail_pulse <= 1'b0;
      step        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cpol_lat    <= 1'b1;
    end else begin
      lead_pulse  <= lead_nxt;
      trail_pulse <= trail_nxt;
      done        <= finish;
      if (accept) begin
        cpol_lat <= cpol;
        sclk     <= cpol;
        step     <= '0;
        cs_n     <= 1'b0;
        busy     <= 1'b1;
      end else if (kill) begin
        sclk <= cpol_lat;
        cs_n <= 1'b1;
        busy <= 1'b0;
      end else if (finish) begin
        cs_n <= 1'b1;
        busy <= 1'b0;
      end else if (toggle) begin
        sclk <= ~sclk;
        if (trail_nxt) begin
          step <= step + BITS_W'(1);
        end
      end
    end
  end

endmodule
